dfr_input_mask: RTL and testbench



---
 rtl/dfr_input_mask.sv | 122 ++++++++++++
 tb/tb_dfr_input_mask.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dfr_input_mask.sv
// Input masking / time-multiplexing stage: each accepted sample is replayed once per
// virtual node with a per-node sign. Optional macro DFR_NEG_SAT_EN saturates -(-2^(W-1)).
module dfr_input_mask #(
    parameter int                       VIRTUAL_NODES = 10,
    parameter int                       DATA_WIDTH    = 32,
    parameter logic [VIRTUAL_NODES-1:0] MASK_INIT     = {VIRTUAL_NODES{1'b1}}
) (
    input  logic                                                        clk,
    input  logic                                                        rst,
    input  logic signed [DATA_WIDTH-1:0]                                din,
    input  logic                                                        din_valid,
    output logic                                                        din_ready,
    input  logic                                                        mask_wr,
    input  logic        [VIRTUAL_NODES-1:0]                             mask_din,
    output logic signed [DATA_WIDTH-1:0]                                dout,
    output logic                                                        dout_valid,
    output logic        [((VIRTUAL_NODES > 2) ? $clog2(VIRTUAL_NODES) : 1)-1:0] node_idx,
    output logic                                                        dout_last
);

    localparam int IDX_W = (VIRTUAL_NODES > 2) ? $clog2(VIRTUAL_NODES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VIRTUAL_NODES - 1);
    localparam logic signed [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [DATA_WIDTH-1:0] MOST_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};

    typedef enum logic {IDLE, RUN} state_t;

    state_t                        state_q;
    logic signed [DATA_WIDTH-1:0]  sample_q;
    logic [VIRTUAL_NODES-1:0]      mask_q;
    logic [VIRTUAL_NODES-1:0]      shadow_q;
    logic [IDX_W-1:0]              idx_q;
    logic signed [DATA_WIDTH-1:0]  dout_q;
    logic                          dout_valid_q;
    logic                          dout_last_q;
    logic                          din_ready_q;

    logic                          accept;
    logic [VIRTUAL_NODES-1:0]      mask_d;
    logic [VIRTUAL_NODES-1:0]      shadow_d;
    logic [IDX_W-1:0]              idx_d;
    logic signed [DATA_WIDTH-1:0]  dout_d;

    function automatic logic signed [DATA_WIDTH-1:0] apply_mask(
        input logic signed [DATA_WIDTH-1:0] s,
        input logic                         pos
    );
        if (pos) return s;
`ifdef DFR_NEG_SAT_EN
        if (s == MOST_NEG) return MOST_POS;
`endif
        return -s;
    endfunction

    // A write coincident with an accept must reach the shadow in the same edge.
    always_comb begin
        accept   = din_valid && din_ready_q;
        mask_d   = mask_wr ? mask_din : mask_q;
        shadow_d = accept ? mask_d : shadow_q;
        idx_d    = accept ? '0 : idx_q + 1'b1;
        dout_d   = apply_mask(accept ? din : sample_q, shadow_d[idx_d]);
    end

    always_ff @(posedge clk) begin
        if (accept) sample_q <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
            din_ready_q  <= 1'b1;
            mask_q       <= MASK_INIT;
            shadow_q     <= MASK_INIT;
        end else begin
            mask_q   <= mask_d;
            shadow_q <= shadow_d;
            if (accept) begin
                state_q      <= RUN;
                idx_q        <= '0;
                dout_q       <= dout_d;
                dout_valid_q <= 1'b1;
                dout_last_q  <= 1'b0;
                din_ready_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        dout_valid_q <= 1'b0;
                        dout_last_q  <= 1'b0;
                        din_ready_q  <= 1'b1;
                    end
                    RUN: begin
                        if (idx_q == LAST_IDX) begin
                            state_q      <= IDLE;
                            idx_q        <= '0;
                            dout_valid_q <= 1'b0;
                            dout_last_q  <= 1'b0;
                            din_ready_q  <= 1'b1;
                        end else begin
                            idx_q        <= idx_d;
                            dout_q       <= dout_d;
                            dout_valid_q <= 1'b1;
                            dout_last_q  <= (idx_d == LAST_IDX);
                            din_ready_q  <= (idx_d == LAST_IDX);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign din_ready  = din_ready_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign node_idx   = idx_q;
    assign dout_last  = dout_last_q;

endmodule

// File: tb/tb_dfr_input_mask.sv
// Bench for dfr_input_mask: directed scenarios plus a randomized run against a queue model.
module tb_dfr_input_mask;

    localparam int VN = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] din;
    logic        din_valid;
    logic        din_ready;
    logic        mask_wr;
    logic [9:0]  mask_din;
    logic [31:0] dout;
    logic        dout_valid;
    logic [3:0]  node_idx;
    logic        dout_last;

    int errs   = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] v;
        int          i;
    } ent_t;

    always #5 clk = ~clk;

    dfr_input_mask dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .mask_wr    (mask_wr),
        .mask_din   (mask_din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .node_idx   (node_idx),
        .dout_last  (dout_last)
    );

    function automatic logic [31:0] model_out(input logic [31:0] s, input logic pos);
        if (pos) return s;
`ifdef DFR_NEG_SAT_EN
        if (s == 32'h8000_0000) return 32'h7FFF_FFFF;
`endif
        return 32'd0 - s;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; din = '0; din_valid = 1'b0; mask_wr = 1'b0; mask_din = '0;
        tick(); tick();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (din_ready !== 1'b1 || dout_valid !== 1'b0 || dout !== 32'd0 ||
                node_idx !== 4'd0 || dout_last !== 1'b0) begin
                errs++;
                $display("FAIL reset_idle c=%0d: rdy=%b vld=%b dout=%h idx=%0d last=%b want 1 0 0 0 0",
                         c, din_ready, dout_valid, dout, node_idx, dout_last);
            end
            tick();
        end
    endtask

    task automatic test_alt_mask();
        logic [9:0]  m = 10'b1010101010;
        logic [31:0] e;
        din = 32'd100; din_valid = 1'b1; mask_wr = 1'b1; mask_din = m;
        tick();
        din_valid = 1'b0; mask_wr = 1'b0;
        for (int i = 0; i < VN; i++) begin
            e = m[i] ? 32'd100 : -32'd100;
            checks++;
            if (dout_valid !== 1'b1 || dout !== e || node_idx !== 4'(i) ||
                dout_last !== (i == VN-1) || din_ready !== (i == VN-1)) begin
                errs++;
                $display("FAIL alt_mask i=%0d: vld=%b dout=%h idx=%0d last=%b rdy=%b want dout=%h",
                         i, dout_valid, dout, node_idx, dout_last, din_ready, e);
            end
            tick();
        end
        checks++;
        if (dout_valid !== 1'b0 || din_ready !== 1'b1 || dout_last !== 1'b0 || dout !== 32'd100) begin
            errs++;
            $display("FAIL alt_mask_idle: vld=%b rdy=%b last=%b dout=%h want 0 1 0 00000064",
                     dout_valid, din_ready, dout_last, dout);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        din = 32'd5; din_valid = 1'b1; mask_wr = 1'b1; mask_din = '1;
        tick();
        mask_wr = 1'b0; din = 32'd7;
        for (int i = 0; i < 2*VN; i++) begin
            e = (i < VN) ? 32'd5 : 32'd7;
            checks++;
            if (dout_valid !== 1'b1 || dout !== e || node_idx !== 4'(i % VN) ||
                din_ready !== ((i % VN) == VN-1) || dout_last !== ((i % VN) == VN-1)) begin
                errs++;
                $display("FAIL b2b i=%0d: vld=%b dout=%h idx=%0d rdy=%b last=%b want dout=%h",
                         i, dout_valid, dout, node_idx, din_ready, dout_last, e);
            end
            if (i == VN) din_valid = 1'b0;
            tick();
        end
        checks++;
        if (dout_valid !== 1'b0 || din_ready !== 1'b1) begin
            errs++;
            $display("FAIL b2b_idle: vld=%b rdy=%b want 0 1", dout_valid, din_ready);
        end
    endtask

    task automatic test_mask_shadow();
        din = 32'd3; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        for (int i = 0; i < VN; i++) begin
            checks++;
            if (dout_valid !== 1'b1 || dout !== 32'd3 || node_idx !== 4'(i)) begin
                errs++;
                $display("FAIL shadow_hold i=%0d: vld=%b dout=%h idx=%0d want dout=00000003",
                         i, dout_valid, dout, node_idx);
            end
            mask_wr = (i == 4); mask_din = '0;
            tick();
        end
        mask_wr = 1'b0;
        din = 32'd3; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        for (int i = 0; i < VN; i++) begin
            checks++;
            if (dout_valid !== 1'b1 || dout !== -32'd3 || node_idx !== 4'(i)) begin
                errs++;
                $display("FAIL shadow_new i=%0d: vld=%b dout=%h idx=%0d want dout=fffffffd",
                         i, dout_valid, dout, node_idx);
            end
            tick();
        end
    endtask

    task automatic test_neg_overflow();
        logic [31:0] e;
`ifdef DFR_NEG_SAT_EN
        e = 32'h7FFF_FFFF;
`else
        e = 32'h8000_0000;
`endif
        din = 32'h8000_0000; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        for (int i = 0; i < VN; i++) begin
            checks++;
            if (dout_valid !== 1'b1 || dout !== e) begin
                errs++;
                $display("FAIL neg_ovf i=%0d: vld=%b dout=%h want %h", i, dout_valid, dout, e);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_run();
        din = 32'd42; din_valid = 1'b1; mask_wr = 1'b1; mask_din = 10'h155;
        tick();
        din_valid = 1'b0; mask_wr = 1'b0;
        repeat (6) tick();
        checks++;
        if (node_idx !== 4'd6 || dout_valid !== 1'b1) begin
            errs++;
            $display("FAIL rst_pre: idx=%0d vld=%b want 6 1", node_idx, dout_valid);
        end
        rst = 1'b1; din_valid = 1'b1; din = 32'd77; mask_wr = 1'b1; mask_din = '0;
        tick();
        rst = 1'b0; din_valid = 1'b0; mask_wr = 1'b0;
        checks++;
        if (dout_valid !== 1'b0 || node_idx !== 4'd0 || din_ready !== 1'b1 ||
            dout !== 32'd0 || dout_last !== 1'b0) begin
            errs++;
            $display("FAIL rst_mid: vld=%b idx=%0d rdy=%b dout=%h last=%b want 0 0 1 0 0",
                     dout_valid, node_idx, din_ready, dout, dout_last);
        end
        din = 32'd9; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        for (int i = 0; i < VN; i++) begin
            checks++;
            if (dout_valid !== 1'b1 || dout !== 32'd9 || node_idx !== 4'(i)) begin
                errs++;
                $display("FAIL rst_restart i=%0d: vld=%b dout=%h idx=%0d want dout=00000009",
                         i, dout_valid, dout, node_idx);
            end
            tick();
        end
    endtask

    task automatic test_random();
        ent_t        q[$];
        ent_t        en;
        logic [9:0]  mmask = '1;
        logic [9:0]  eff;
        logic [31:0] last_dout = 32'd9;
        logic        exp_rdy;
        for (int c = 0; c < 600; c++) begin
            exp_rdy = (q.size() <= 1);
            checks++;
            if (q.size() > 0) begin
                en = q.pop_front();
                if (dout_valid !== 1'b1 || dout !== en.v || node_idx !== 4'(en.i) ||
                    dout_last !== (en.i == VN-1) || din_ready !== exp_rdy) begin
                    errs++;
                    $display("FAIL rand c=%0d: vld=%b dout=%h idx=%0d last=%b rdy=%b want dout=%h idx=%0d rdy=%b",
                             c, dout_valid, dout, node_idx, dout_last, din_ready, en.v, en.i, exp_rdy);
                end
                last_dout = en.v;
            end else if (dout_valid !== 1'b0 || dout_last !== 1'b0 || dout !== last_dout ||
                         din_ready !== 1'b1) begin
                errs++;
                $display("FAIL rand_idle c=%0d: vld=%b last=%b dout=%h rdy=%b want 0 0 %h 1",
                         c, dout_valid, dout_last, dout, din_ready, last_dout);
            end
            if (c < 580) begin
                din_valid = ($urandom_range(0, 3) != 0);
                din       = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
                mask_wr   = ($urandom_range(0, 5) == 0);
                mask_din  = 10'($urandom);
            end else begin
                din_valid = 1'b0;
                mask_wr   = 1'b0;
            end
            eff = mask_wr ? mask_din : mmask;
            mmask = eff;
            if (din_valid && exp_rdy) begin
                for (int n = 0; n < VN; n++) q.push_back('{v: model_out(din, eff[n]), i: n});
            end
            tick();
        end
        din_valid = 1'b0; mask_wr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alt_mask();
        test_back_to_back();
        test_mask_shadow();
        test_neg_overflow();
        test_reset_mid_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
